regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with write-to-read bypass and a per-register busy scoreboard, successor to the single-write, two-read register file in the decode stage. It serves NRD combinational read ports and two synchronous write ports (ALU and load/long-latency writeback). It tracks which destination registers have in-flight writes so the hazard unit can stall without separate bookkeeping.

## Interface
- XLEN, 32, data width of each register
- NREG, 32, number of architectural registers (power of two, ≥2); AW = $clog2(NREG) is derived
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, register 0 reads as zero, is never written and is never busy
- BYPASS, 1, when 1, same-cycle write data is forwarded to read ports

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- rd_addr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
- rd_busy  out  NRD  register addressed by port i has a pending write
- wr_en  in  2  write enables, port 0 and port 1
- wr_addr  in  2*AW  write addresses, port k at [k*AW +: AW]
- wr_data  in  2*XLEN  write data, port k at [k*XLEN +: XLEN]
- issue_en  in  1  an instruction with a destination register is issued this cycle
- issue_addr  in  AW  destination register of the issued instruction
- busy_count  out  AW+1  number of registers currently marked busy

## Operation
- Storage: NREG x XLEN array plus NREG busy bits plus busy_count register.
- Write: on posedge clk, for each k with wr_en[k], reg[wr_addr[k]] <= wr_data[k]. Both ports write the same address in one cycle: port 1 wins.
- ZERO_REG=1: writes to address 0 are dropped. Issues to address 0 are dropped. Reads of address 0 return 0 with rd_busy=0, regardless of bypass.
- Read, combinational per port i:
  - BYPASS=1 and wr_en[1] with matching address: wr_data[1].
  - Else BYPASS=1 and wr_en[0] with matching address: wr_data[0].
  - Else the stored value.
- Scoreboard, next-state per register r:
  - Cleared by any wr_en[k] with wr_addr[k]==r.
  - Set by issue_en with issue_addr==r.
  - Set and clear in the same cycle for the same r: busy stays 1, because the new issue supersedes the old writeback.
- rd_busy[i] = busy[rd_addr[i]], masked to 0 when BYPASS=1 and a write to that address is enabled this cycle, unless issue_en targets the same address.
- busy_count: registered population count of busy bits. It is updated each cycle by (+1 if a clear bit becomes set) and (−1 per busy bit cleared). Two write ports clearing the same register count once. busy_count always equals popcount(busy) one cycle after any change.
- Writes to a non-busy register are legal; they update data and leave busy at 0.

## Timing
- Reset, asynchronous, takes effect immediately: all registers 0, all busy bits 0, busy_count 0. rd_data becomes 0 and rd_busy 0 combinationally for any address.
- Reset asserted mid-operation discards pending writes and issues in that cycle. The first write after deassertion takes effect on the first rising edge with reset low.
- Read latency: 0 cycles (combinational from rd_addr, and from wr_* when BYPASS=1).
- Write latency: data visible from stored array 1 cycle after the write edge. With BYPASS=1 it is also visible in the write cycle itself.
- Scoreboard latency: busy set/cleared at the edge following issue_en/wr_en. rd_busy reflects the new state from that edge, except for the bypass masking above.
- busy_count range 0..NREG (NREG−1 when ZERO_REG=1); it never wraps.

## Test plan
- Reset then read all addresses on every port -> rd_data=0, rd_busy=0, busy_count=0. Assert reset mid-write burst -> state zeroed immediately.
- wr_en=2'b01, wr_addr[0]=5, wr_data[0]=0xDEADBEEF, rd_addr[0]=5 same cycle -> rd_data[0]=0xDEADBEEF (BYPASS=1) and stored value next cycle. Repeat with BYPASS=0 -> old value same cycle, new value next cycle.
- Both ports write address 7 (0x11111111 on port 0, 0x22222222 on port 1) -> read 7 returns 0x22222222 same cycle and after.
- issue_en to 9 -> next cycle rd_busy=1, busy_count=1. Writeback to 9 with issue_en to 9 in the same cycle -> busy stays 1, count stays 1. Writeback alone -> busy 0, count 0.
- ZERO_REG=1: write 0xFFFFFFFF to 0 and issue to 0 -> reads 0, rd_busy 0, busy_count unchanged.
- Issue registers 1..NREG−1 on consecutive cycles -> busy_count reaches NREG−1 with no wrap. Two ports clearing 3 and 4 in one cycle -> count decreases by 2.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with write-to-read bypass
// and a per-register busy scoreboard for the hazard unit.
// NRD combinational read ports and two synchronous write ports (ALU, load).
// On a same-address write collision, port 1 takes priority.
module regfile_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [1:0]          wr_en,
  input  logic [2*AW-1:0]     wr_addr,
  input  logic [2*XLEN-1:0]   wr_data,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_addr,
  output logic [AW:0]         busy_count
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [AW:0]     busy_count_q;
  logic [AW:0]     busy_count_d;

  logic [AW-1:0]   waddr [2];
  logic [XLEN-1:0] wdata [2];
  logic [1:0]      wr_ok;
  logic            issue_ok;
  logic [AW-1:0]   raddr [NRD];

  logic            set_new;
  logic            clr0;
  logic            clr1;

  // Unpack write ports and drop writes/issues aimed at the hardwired zero register
  always_comb begin
    for (int unsigned k = 0; k < 2; k++) begin
      waddr[k] = wr_addr[k*AW +: AW];
      wdata[k] = wr_data[k*XLEN +: XLEN];
      wr_ok[k] = wr_en[k] && !((ZERO_REG != 0) && (waddr[k] == '0));
    end
    issue_ok = issue_en && !((ZERO_REG != 0) && (issue_addr == '0));
  end

  // Next register contents; port 1 is applied last so it wins a collision
  always_comb begin
    regs_d = regs_q;
    for (int unsigned k = 0; k < 2; k++) begin
      if (wr_ok[k]) begin
        regs_d[waddr[k]] = wdata[k];
      end
    end
  end

  // Scoreboard next state: writeback clears, issue sets, and issue takes precedence
  always_comb begin
    busy_d = busy_q;
    for (int unsigned k = 0; k < 2; k++) begin
      if (wr_ok[k]) begin
        busy_d[waddr[k]] = 1'b0;
      end
    end
    if (issue_ok) begin
      busy_d[issue_addr] = 1'b1;
    end
  end

  // Incremental population count; a register cleared by both ports is counted once,
  // and a clear cancelled by a same-cycle issue is not counted at all
  always_comb begin
    set_new = issue_ok && !busy_q[issue_addr];
    clr0    = wr_ok[0] && busy_q[waddr[0]] &&
              !(issue_ok && (issue_addr == waddr[0]));
    clr1    = wr_ok[1] && busy_q[waddr[1]] &&
              !(issue_ok && (issue_addr == waddr[1])) &&
              !(wr_ok[0] && (waddr[0] == waddr[1]));
    busy_count_d = busy_count_q
                 + {{AW{1'b0}}, set_new}
                 - {{AW{1'b0}}, clr0}
                 - {{AW{1'b0}}, clr1};
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  // Combinational read ports with optional same-cycle forwarding and busy masking;
  // outputs are forced to zero while reset is held so no bypassed data leaks out
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      raddr[i] = rd_addr[i*AW +: AW];
      if (!reset && !((ZERO_REG != 0) && (raddr[i] == '0))) begin
        rd_data[i*XLEN +: XLEN] = regs_q[raddr[i]];
        rd_busy[i]              = busy_q[raddr[i]];
        if (BYPASS != 0) begin
          if (wr_en[0] && (waddr[0] == raddr[i])) begin
            rd_data[i*XLEN +: XLEN] = wdata[0];
          end
          if (wr_en[1] && (waddr[1] == raddr[i])) begin
            rd_data[i*XLEN +: XLEN] = wdata[1];
          end
          if (((wr_en[0] && (waddr[0] == raddr[i])) ||
               (wr_en[1] && (waddr[1] == raddr[i]))) &&
              !(issue_en && (issue_addr == raddr[i]))) begin
            rd_busy[i] = 1'b0;
          end
        end
      end
    end
  end

  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural array model. Two instances share all
// inputs, one with forwarding enabled and one without.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_addr;

  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic [5:0]  busy_count_a, busy_count_b;

  int checks = 0;
  int errors = 0;

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_count(busy_count_a)
  );

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_count(busy_count_b)
  );

  always #5 clk = ~clk;

  // Behavioural model: architectural contents and busy flags
  logic [31:0] m_mem  [32];
  logic        m_busy [32];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        m_mem[r]  <= '0;
        m_busy[r] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wr_en[k] && wr_addr[k*5 +: 5] != 5'd0) begin
          m_mem[wr_addr[k*5 +: 5]]  <= wr_data[k*32 +: 32];
          m_busy[wr_addr[k*5 +: 5]] <= 1'b0;
        end
      end
      if (issue_en && issue_addr != 5'd0) m_busy[issue_addr] <= 1'b1;
    end
  end

  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  function automatic logic write_hits(input logic [4:0] a);
    return (wr_en[0] && wr_addr[4:0] == a) || (wr_en[1] && wr_addr[9:5] == a);
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    if (reset || a == 5'd0) return 32'd0;
    if (byp && wr_en[1] && wr_addr[9:5] == a) return wr_data[63:32];
    if (byp && wr_en[0] && wr_addr[4:0] == a) return wr_data[31:0];
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (reset || a == 5'd0) return 1'b0;
    if (byp && write_hits(a) && !(issue_en && issue_addr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [4:0] a;
      a = rd_addr[i*5 +: 5];
      chk($sformatf("rd_data_byp[%0d] addr %0d", i, a), 64'(rd_data_a[i*32 +: 32]), 64'(exp_data(a, 1'b1)));
      chk($sformatf("rd_busy_byp[%0d] addr %0d", i, a), 64'(rd_busy_a[i]), 64'(exp_busy(a, 1'b1)));
      chk($sformatf("rd_data_nob[%0d] addr %0d", i, a), 64'(rd_data_b[i*32 +: 32]), 64'(exp_data(a, 1'b0)));
      chk($sformatf("rd_busy_nob[%0d] addr %0d", i, a), 64'(rd_busy_b[i]), 64'(exp_busy(a, 1'b0)));
    end
    chk("busy_count_byp", 64'(busy_count_a), 64'(m_count()));
    chk("busy_count_nob", 64'(busy_count_b), 64'(m_count()));
  end

  task automatic drive(input logic [1:0] we, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic ie, input logic [4:0] ia,
                       input logic [4:0] r0, input logic [4:0] r1);
    wr_en      = we;
    wr_addr    = {a1, a0};
    wr_data    = {d1, d0};
    issue_en   = ie;
    issue_addr = ia;
    rd_addr    = {r1, r0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycle();
    logic [4:0] a0, a1, ia, r0, r1;
    a0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    a1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    ia = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    r0 = ($urandom_range(0, 2) == 0) ? a0 : 5'($urandom_range(0, 31));
    r1 = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 7));
    drive(2'($urandom), a0, a1, $urandom, $urandom, ($urandom_range(0, 2) != 0), ia, r0, r1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);
    #1 reset = 1'b1;
    #1;
    chk("reset_count_async", 64'(busy_count_a), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Every address reads zero and idle after reset
    for (int a = 0; a < 32; a++) begin
      drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'(a), 5'(31 - a));
      @(negedge clk);
      chk("post_reset_rd", rd_data_a, 64'd0);
      tick();
    end

    // Single write with same-cycle read
    drive(2'b01, 5, 0, 32'hDEADBEEF, 0, 1'b0, 0, 5, 5);
    @(negedge clk);
    chk("bypass_same_cycle", 64'(rd_data_a[31:0]), 64'hDEADBEEF);
    chk("nobypass_old_value", 64'(rd_data_b[31:0]), 64'd0);
    tick();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5, 5);
    @(negedge clk);
    chk("stored_byp", 64'(rd_data_a[31:0]), 64'hDEADBEEF);
    chk("stored_nob", 64'(rd_data_b[31:0]), 64'hDEADBEEF);
    chk("model_mem5", 64'(m_mem[5]), 64'hDEADBEEF);
    tick();

    // Both ports to the same address: port 1 wins
    drive(2'b11, 7, 7, 32'h11111111, 32'h22222222, 1'b0, 0, 7, 5);
    @(negedge clk);
    chk("collide_bypass", 64'(rd_data_a[31:0]), 64'h22222222);
    chk("other_port", 64'(rd_data_a[63:32]), 64'hDEADBEEF);
    tick();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 7, 7);
    @(negedge clk);
    chk("collide_stored", 64'(rd_data_b[31:0]), 64'h22222222);
    tick();

    // Scoreboard: issue, writeback-with-reissue, writeback alone
    drive(2'b00, 0, 0, 0, 0, 1'b1, 9, 9, 9);
    @(negedge clk);
    chk("issue_not_yet", 64'(rd_busy_a[0]), 64'd0);
    tick();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 9, 9);
    @(negedge clk);
    chk("busy_after_issue", 64'(rd_busy_a[0]), 64'd1);
    chk("count_after_issue", 64'(busy_count_a), 64'd1);
    tick();
    drive(2'b01, 9, 0, 32'h0000AAAA, 0, 1'b1, 9, 9, 9);
    @(negedge clk);
    chk("reissue_not_masked", 64'(rd_busy_a[0]), 64'd1);
    tick();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 9, 9);
    @(negedge clk);
    chk("reissue_busy", 64'(rd_busy_a[0]), 64'd1);
    chk("reissue_count", 64'(busy_count_a), 64'd1);
    chk("reissue_data", 64'(rd_data_a[31:0]), 64'h0000AAAA);
    tick();
    drive(2'b10, 0, 9, 0, 32'h0000BBBB, 1'b0, 0, 9, 9);
    @(negedge clk);
    chk("wb_masked_byp", 64'(rd_busy_a[0]), 64'd0);
    chk("wb_unmasked_nob", 64'(rd_busy_b[0]), 64'd1);
    tick();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 9, 9);
    @(negedge clk);
    chk("wb_cleared", 64'(rd_busy_b[0]), 64'd0);
    chk("wb_count", 64'(busy_count_a), 64'd0);
    tick();

    // Register zero ignores writes and issues
    drive(2'b01, 0, 0, 32'hFFFFFFFF, 0, 1'b1, 0, 0, 0);
    @(negedge clk);
    chk("zero_rd_bypass", rd_data_a, 64'd0);
    chk("zero_busy", 64'(rd_busy_a), 64'd0);
    tick();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);
    @(negedge clk);
    chk("zero_count", 64'(busy_count_a), 64'd0);
    tick();

    // Fill the scoreboard, then clear two registers in one cycle
    for (int r = 1; r < 32; r++) begin
      drive(2'b00, 0, 0, 0, 0, 1'b1, 5'(r), 5'(r), 0);
      tick();
    end
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 31, 1);
    @(negedge clk);
    chk("full_count", 64'(busy_count_a), 64'd31);
    chk("model_full_count", 64'(m_count()), 64'd31);
    tick();
    drive(2'b11, 3, 4, 32'h3, 32'h4, 1'b0, 0, 3, 4);
    tick();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 3, 4);
    @(negedge clk);
    chk("dual_clear_count", 64'(busy_count_a), 64'd29);
    tick();
    for (int r = 1; r < 32; r += 2) begin
      drive(2'b11, 5'(r), 5'(r + 1), 32'(r), 32'(r + 1), 1'b0, 0, 5'(r), 0);
      tick();
    end
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 1, 2);
    @(negedge clk);
    chk("drained_count", 64'(busy_count_a), 64'd0);
    tick();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rand_cycle();
      tick();
    end

    // Reset in the middle of a write burst
    rand_cycle();
    wr_en = 2'b11;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midreset_rd", rd_data_a, 64'd0);
    chk("midreset_busy", 64'(rd_busy_a), 64'd0);
    chk("midreset_count", 64'(busy_count_a), 64'd0);
    @(negedge clk);
    #1;
    drive(2'b01, 12, 0, 32'hCAFEF00D, 0, 1'b1, 12, 12, 12);
    reset = 1'b0;
    tick();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 12, 12);
    @(negedge clk);
    chk("first_write_after_reset", 64'(rd_data_b[31:0]), 64'hCAFEF00D);
    chk("first_issue_after_reset", 64'(busy_count_a), 64'd1);
    tick();

    for (int n = 0; n < 200; n++) begin
      rand_cycle();
      tick();
    end

    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
